// File: rtl/ame_pkg.sv
// rtl/ame_pkg.sv - shared constants, FSM states and index map for the affine equation path
//
// Purpose: definitions shared by ame_equation_builder, ame_coef_gen and the
// downstream solver: element width default, coefficient index constants, the
// FSM state encoding and the upper-triangle accumulator index map.
package ame_pkg;

  // Element width of the 6x7 system handed to the solver.
  localparam int AME_COMP_DATA_BITS = 64;

  // Coefficient indices in 6-parameter mode.
  localparam int C_GX  = 0;
  localparam int C_XGX = 1;
  localparam int C_GY  = 2;
  localparam int C_XGY = 3;
  localparam int C_YGX = 4;
  localparam int C_YGY = 5;

  localparam int N_COEF = 6;
  localparam int N_UT   = 21;           // upper triangle of the 6x6 matrix A
  localparam int N_PROD = N_UT + N_COEF; // A products followed by B products

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WAIT  = 2'd3
  } ame_state_e;

  // Upper-triangle map: (i, j) with j >= i -> flat accumulator index 0..20,
  // row-major (row 0 owns 0..5, row 1 owns 6..10, ..., row 5 owns 20).
  function automatic int ut_idx(input int i, input int j);
    return i * N_COEF - (i * (i - 1)) / 2 + (j - i);
  endfunction

endpackage

// File: rtl/ame_coef_gen.sv
// rtl/ame_coef_gen.sv - per-pixel affine coefficient formation with S1 register
//
// Purpose: forms the six mode-dependent affine coefficients for one pixel and
// registers them together with the residual and the block side-band data.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_en                beat accepted this cycle (loads S1)
//   i_first, i_mode6    first-beat flag and block mode for this beat
//   i_tag               block tag travelling with the beat
//   i_gx, i_gy, i_res   signed gradients and residual
//   i_x, i_y            unsigned block-relative coordinates
//   o_valid             S1 holds a beat
//   o_first, o_mode6, o_tag, o_res, o_coef  registered beat contents
module ame_coef_gen
  import ame_pkg::*;
#(
  parameter int GRAD_BITS  = 16,
  parameter int COORD_BITS = 7,
  parameter int COEF_BITS  = GRAD_BITS + COORD_BITS + 2
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_en,
  input  logic                                i_first,
  input  logic                                i_mode6,
  input  logic [7:0]                          i_tag,
  input  logic signed [GRAD_BITS-1:0]         i_gx,
  input  logic signed [GRAD_BITS-1:0]         i_gy,
  input  logic signed [GRAD_BITS-1:0]         i_res,
  input  logic [COORD_BITS-1:0]               i_x,
  input  logic [COORD_BITS-1:0]               i_y,
  output logic                                o_valid,
  output logic                                o_first,
  output logic                                o_mode6,
  output logic [7:0]                          o_tag,
  output logic signed [GRAD_BITS-1:0]         o_res,
  output logic [N_COEF-1:0][COEF_BITS-1:0]    o_coef
);

  logic signed [COEF_BITS-1:0]       w_gx, w_gy, w_x, w_y;
  logic [N_COEF-1:0][COEF_BITS-1:0]  w_coef;

  always_comb begin
    w_gx   = COEF_BITS'(i_gx);
    w_gy   = COEF_BITS'(i_gy);
    w_x    = COEF_BITS'({1'b0, i_x});
    w_y    = COEF_BITS'({1'b0, i_y});
    w_coef = '0;
    if (i_mode6) begin
      w_coef[C_GX]  = w_gx;
      w_coef[C_XGX] = w_x * w_gx;
      w_coef[C_GY]  = w_gy;
      w_coef[C_XGY] = w_x * w_gy;
      w_coef[C_YGX] = w_y * w_gx;
      w_coef[C_YGY] = w_y * w_gy;
    end else begin
      // 4-param terms occupy slots 2..5 so slots 0..1 (and their A/B rows)
      // accumulate zero without any special casing downstream.
      w_coef[2] = w_gx;
      w_coef[3] = w_x * w_gx + w_y * w_gy;
      w_coef[4] = w_gy;
      w_coef[5] = w_y * w_gx - w_x * w_gy;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      o_mode6 <= 1'b0;
      o_tag   <= '0;
      o_res   <= '0;
      o_coef  <= '0;
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        o_first <= i_first;
        o_mode6 <= i_mode6;
        o_tag   <= i_tag;
        o_res   <= i_res;
        o_coef  <= w_coef;
      end
    end
  end

endmodule

// File: rtl/ame_equation_builder.sv
// rtl/ame_equation_builder.sv - accumulates the affine normal equations of one block for the solver
//
// Purpose: consumes one pixel per cycle, forms the affine coefficient vector,
// accumulates the symmetric matrix A (upper triangle) and vector B over a
// block and hands the 6x7 system to ame_equation_solver via comp_init/comp_load.
// Pipeline: S1 coefficients (ame_coef_gen), S2 products, S3 accumulators.
// Optional build macro: AME_BUILDER_SAT_EN - saturating signed accumulation
// instead of two's-complement wrap.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   pix_valid_i/pix_ready_o/pix_last_i  pixel beat handshake
//   pix_gx_i, pix_gy_i, pix_res_i     signed gradients and residual
//   pix_x_i, pix_y_i                  block-relative coordinates
//   affine_param6_i, blk_index_i      mode and tag, sampled on the first beat
//   comp_load_i                       solver ready
//   comp_init_o                       one-cycle start pulse to the solver
//   affine_param6_o, comp_data_index_o  latched mode and tag
//   comp_data_o                       [i][j<6] = A[i][j], [i][6] = B[i]
module ame_equation_builder
  import ame_pkg::*;
#(
  parameter int GRAD_BITS      = 16,
  parameter int COORD_BITS     = 7,
  parameter int COMP_DATA_BITS = AME_COMP_DATA_BITS
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    pix_valid_i,
  output logic                                    pix_ready_o,
  input  logic                                    pix_last_i,
  input  logic signed [GRAD_BITS-1:0]             pix_gx_i,
  input  logic signed [GRAD_BITS-1:0]             pix_gy_i,
  input  logic signed [GRAD_BITS-1:0]             pix_res_i,
  input  logic [COORD_BITS-1:0]                   pix_x_i,
  input  logic [COORD_BITS-1:0]                   pix_y_i,
  input  logic                                    affine_param6_i,
  input  logic [7:0]                              blk_index_i,
  input  logic                                    comp_load_i,
  output logic                                    comp_init_o,
  output logic                                    affine_param6_o,
  output logic [5:0][6:0][COMP_DATA_BITS-1:0]     comp_data_o,
  output logic [7:0]                              comp_data_index_o
);

  localparam int COEF_BITS = GRAD_BITS + COORD_BITS + 2;
  localparam int PROD_BITS = 2 * COEF_BITS;
`ifdef AME_BUILDER_SAT_EN
  localparam int EXT_BITS  = PROD_BITS + COMP_DATA_BITS;
`endif

  // Brings a full-precision product to the accumulator width.
  function automatic logic signed [COMP_DATA_BITS-1:0] fit_prod(
    input logic signed [PROD_BITS-1:0] p
  );
`ifdef AME_BUILDER_SAT_EN
    logic signed [EXT_BITS-1:0] pe, hi, lo;
    pe = EXT_BITS'(p);
    hi = EXT_BITS'({1'b0, {(COMP_DATA_BITS-1){1'b1}}});
    lo = ~hi;
    if (pe > hi)      return hi[COMP_DATA_BITS-1:0];
    else if (pe < lo) return lo[COMP_DATA_BITS-1:0];
    else              return pe[COMP_DATA_BITS-1:0];
`else
    return COMP_DATA_BITS'(p);
`endif
  endfunction

  function automatic logic signed [COMP_DATA_BITS-1:0] acc_add(
    input logic signed [COMP_DATA_BITS-1:0] a,
    input logic signed [COMP_DATA_BITS-1:0] b
  );
    logic signed [COMP_DATA_BITS-1:0] s;
    s = a + b;
`ifdef AME_BUILDER_SAT_EN
    // Overflow only when both operands share a sign the sum does not.
    if ((a[COMP_DATA_BITS-1] == b[COMP_DATA_BITS-1]) &&
        (s[COMP_DATA_BITS-1] != a[COMP_DATA_BITS-1]))
      s = a[COMP_DATA_BITS-1] ? {1'b1, {(COMP_DATA_BITS-1){1'b0}}}
                              : {1'b0, {(COMP_DATA_BITS-1){1'b1}}};
`endif
    return s;
  endfunction

  // ---------------- control FSM ----------------
  ame_state_e r_state, w_state_nxt;
  logic       r_drain, w_drain_nxt;
  logic       r_init, w_init_nxt;
  logic       r_mode;
  logic       w_accept, w_first, w_mode;

  assign pix_ready_o = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_accept    = pix_valid_i && pix_ready_o;
  assign w_first     = (r_state == ST_IDLE);
  // The block mode is taken from the first beat and held for the rest.
  assign w_mode      = w_first ? affine_param6_i : r_mode;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_drain <= 1'b0;
      r_init  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drain <= w_drain_nxt;
      r_init  <= w_init_nxt;
      if (w_accept && w_first) r_mode <= affine_param6_i;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain;
    w_init_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = pix_last_i ? ST_DRAIN : ST_ACCUM;
          w_drain_nxt = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (w_accept && pix_last_i) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = 1'b0;
        end
      end
      // Two cycles: the last beat is in S1, then in S2; it lands in S3 on
      // the edge that enters WAIT.
      ST_DRAIN: begin
        if (r_drain) w_state_nxt = ST_WAIT;
        else         w_drain_nxt = 1'b1;
      end
      ST_WAIT: begin
        if (comp_load_i) begin
          w_state_nxt = ST_IDLE;
          w_init_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign comp_init_o = r_init;

  // ---------------- S1: coefficients ----------------
  logic                              w_s1_valid, w_s1_first, w_s1_mode;
  logic [7:0]                        w_s1_tag;
  logic signed [GRAD_BITS-1:0]       w_s1_res;
  logic [N_COEF-1:0][COEF_BITS-1:0]  w_s1_coef;

  ame_coef_gen #(
    .GRAD_BITS  (GRAD_BITS),
    .COORD_BITS (COORD_BITS),
    .COEF_BITS  (COEF_BITS)
  ) u_coef_gen (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_en    (w_accept),
    .i_first (w_first),
    .i_mode6 (w_mode),
    .i_tag   (blk_index_i),
    .i_gx    (pix_gx_i),
    .i_gy    (pix_gy_i),
    .i_res   (pix_res_i),
    .i_x     (pix_x_i),
    .i_y     (pix_y_i),
    .o_valid (w_s1_valid),
    .o_first (w_s1_first),
    .o_mode6 (w_s1_mode),
    .o_tag   (w_s1_tag),
    .o_res   (w_s1_res),
    .o_coef  (w_s1_coef)
  );

  // ---------------- S2: products ----------------
  logic signed [COEF_BITS-1:0]       w_c [N_COEF];
  logic signed [COEF_BITS-1:0]       w_r;
  logic signed [COMP_DATA_BITS-1:0]  w_prod [N_PROD];

  always_comb begin
    for (int k = 0; k < N_COEF; k++) w_c[k] = $signed(w_s1_coef[k]);
    w_r = COEF_BITS'(w_s1_res);
  end

  for (genvar gi = 0; gi < N_COEF; gi++) begin : g_row
    for (genvar gj = gi; gj < N_COEF; gj++) begin : g_col
      assign w_prod[ut_idx(gi, gj)] =
        fit_prod(PROD_BITS'(w_c[gi]) * PROD_BITS'(w_c[gj]));
    end
    assign w_prod[N_UT + gi] = fit_prod(PROD_BITS'(w_c[gi]) * PROD_BITS'(w_r));
  end

  logic                              r_s2_valid, r_s2_first, r_s2_mode;
  logic [7:0]                        r_s2_tag;
  logic signed [COMP_DATA_BITS-1:0]  r_s2_prod [N_PROD];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_tag   <= '0;
      for (int k = 0; k < N_PROD; k++) r_s2_prod[k] <= '0;
    end else begin
      r_s2_valid <= w_s1_valid;
      if (w_s1_valid) begin
        r_s2_first <= w_s1_first;
        r_s2_mode  <= w_s1_mode;
        r_s2_tag   <= w_s1_tag;
        for (int k = 0; k < N_PROD; k++) r_s2_prod[k] <= w_prod[k];
      end
    end
  end

  // ---------------- S3: accumulators ----------------
  logic signed [COMP_DATA_BITS-1:0]  r_acc [N_PROD];
  logic [7:0]                        r_tag;
  logic                              r_mode_out;

  // The first beat of a block overwrites, so blocks need no clear cycle and
  // the previous result stays visible until this very edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag      <= '0;
      r_mode_out <= 1'b0;
      for (int k = 0; k < N_PROD; k++) r_acc[k] <= '0;
    end else if (r_s2_valid) begin
      for (int k = 0; k < N_PROD; k++)
        r_acc[k] <= r_s2_first ? r_s2_prod[k] : acc_add(r_acc[k], r_s2_prod[k]);
      if (r_s2_first) begin
        r_tag      <= r_s2_tag;
        r_mode_out <= r_s2_mode;
      end
    end
  end

  // Lower triangle of A mirrors the upper triangle.
  always_comb begin
    comp_data_o = '0;
    for (int i = 0; i < N_COEF; i++) begin
      for (int j = 0; j < N_COEF; j++) begin
        if (j >= i) comp_data_o[i][j] = r_acc[ut_idx(i, j)];
        else        comp_data_o[i][j] = r_acc[ut_idx(j, i)];
      end
      comp_data_o[i][6] = r_acc[N_UT + i];
    end
  end

  assign comp_data_index_o = r_tag;
  assign affine_param6_o   = r_mode_out;

endmodule

// File: tb/tb_ame_equation_builder.sv
// tb/tb_ame_equation_builder.sv - scoreboard testbench for ame_equation_builder
module tb_ame_equation_builder;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               pix_valid_i, pix_last_i, affine_param6_i, comp_load_i;
  logic signed [15:0] pix_gx_i, pix_gy_i, pix_res_i;
  logic [6:0]         pix_x_i, pix_y_i;
  logic [7:0]         blk_index_i;

  logic                  pix_ready_o, comp_init_o, affine_param6_o;
  logic [5:0][6:0][63:0] comp_data_o;
  logic [7:0]            comp_data_index_o;

  logic                  ready32, init32, mode32;
  logic [5:0][6:0][31:0] data32;
  logic [7:0]            idx32;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ame_equation_builder #(.GRAD_BITS(16), .COORD_BITS(7), .COMP_DATA_BITS(64)) dut (
    .clk_i(clk), .rst_i(rst_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_last_i(pix_last_i), .pix_gx_i(pix_gx_i), .pix_gy_i(pix_gy_i),
    .pix_res_i(pix_res_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .affine_param6_i(affine_param6_i), .blk_index_i(blk_index_i),
    .comp_load_i(comp_load_i), .comp_init_o(comp_init_o),
    .affine_param6_o(affine_param6_o), .comp_data_o(comp_data_o),
    .comp_data_index_o(comp_data_index_o)
  );

  ame_equation_builder #(.GRAD_BITS(16), .COORD_BITS(7), .COMP_DATA_BITS(32)) dut32 (
    .clk_i(clk), .rst_i(rst_i), .pix_valid_i(pix_valid_i), .pix_ready_o(ready32),
    .pix_last_i(pix_last_i), .pix_gx_i(pix_gx_i), .pix_gy_i(pix_gy_i),
    .pix_res_i(pix_res_i), .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .affine_param6_i(affine_param6_i), .blk_index_i(blk_index_i),
    .comp_load_i(comp_load_i), .comp_init_o(init32),
    .affine_param6_o(mode32), .comp_data_o(data32),
    .comp_data_index_o(idx32)
  );

  typedef struct { int gx; int gy; int res; int x; int y; } pix_t;
  typedef struct { logic [5:0][6:0][63:0] m; logic [7:0] tag; logic mode; } exp_t;

  pix_t        blk[$];
  exp_t        exp_q[$];
  logic [63:0] probe_val;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%h exp=%h", name, obs, exp);
    end
  endtask

  task automatic add_pix(input int gx, input int gy, input int res, input int x, input int y);
    blk.push_back('{gx, gy, res, x, y});
  endtask

  // Reference: full A and B built from the coefficient definitions.
  function automatic exp_t model(input bit mode, input logic [7:0] tag);
    exp_t   e;
    longint c[6];
    longint a[6][7];
    for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) a[i][j] = 0;
    foreach (blk[p]) begin
      longint gx, gy, x, y;
      gx = blk[p].gx; gy = blk[p].gy; x = blk[p].x; y = blk[p].y;
      if (mode) begin
        c[0] = gx; c[1] = x*gx; c[2] = gy; c[3] = x*gy; c[4] = y*gx; c[5] = y*gy;
      end else begin
        c[0] = 0; c[1] = 0; c[2] = gx; c[3] = x*gx + y*gy; c[4] = gy; c[5] = y*gx - x*gy;
      end
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) a[i][j] += c[i] * c[j];
        a[i][6] += c[i] * longint'(blk[p].res);
      end
    end
    for (int i = 0; i < 6; i++) for (int j = 0; j < 7; j++) e.m[i][j] = a[i][j];
    e.tag  = tag;
    e.mode = mode;
    return e;
  endfunction

  task automatic beat(input pix_t px, input bit last, input bit mode, input logic [7:0] tag);
    int n = 0;
    while (pix_ready_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    pix_valid_i = 1'b1; pix_last_i = last;
    pix_gx_i = 16'(px.gx); pix_gy_i = 16'(px.gy); pix_res_i = 16'(px.res);
    pix_x_i = 7'(px.x); pix_y_i = 7'(px.y);
    affine_param6_i = mode; blk_index_i = tag;
    @(posedge clk); #1;
    pix_valid_i = 1'b0; pix_last_i = 1'b0;
  endtask

  // Later beats carry a flipped mode and tag: only the first beat may count.
  task automatic send_block(input bit mode, input logic [7:0] tag, input int probe_after);
    exp_q.push_back(model(mode, tag));
    foreach (blk[k]) begin
      beat(blk[k], k == blk.size() - 1, (k == 0) ? mode : ~mode, (k == 0) ? tag : ~tag);
      if (k + 1 == probe_after) probe_val = comp_data_o[0][6];
    end
  endtask

  task automatic check_result(input string name, input int exp_lat);
    int   n = 0;
    int   fi = 0, fj = 0;
    bit   found = 0;
    exp_t e;
    while (comp_init_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    chk({name, "_init"}, comp_init_o, 1);
    if (exp_lat >= 0) chk({name, "_latency"}, n, exp_lat);
    chk({name, "_ready_at_init"}, pix_ready_o, 1);
    chk({name, "_sb_nonempty"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '{default: '0};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        if (!found && comp_data_o[i][j] !== e.m[i][j]) begin fi = i; fj = j; found = 1; end
    n_cmp++;
    assert (comp_data_o === e.m) else begin
      n_bad++;
      $error("FAIL %s_data [%0d][%0d] obs=%h exp=%h", name, fi, fj,
             comp_data_o[fi][fj], e.m[fi][fj]);
    end
    chk({name, "_tag"}, comp_data_index_o, e.tag);
    chk({name, "_mode"}, affine_param6_o, e.mode);
    @(posedge clk); #1;
    chk({name, "_one_pulse"}, comp_init_o, 0);
  endtask

  initial begin
    logic [5:0][6:0][63:0] snap;
    longint                p;
    logic [31:0]           exp32;

    rst_i = 1'b1; pix_valid_i = 0; pix_last_i = 0; affine_param6_i = 0;
    comp_load_i = 1'b1; pix_gx_i = 0; pix_gy_i = 0; pix_res_i = 0;
    pix_x_i = 0; pix_y_i = 0; blk_index_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // Reset state
    chk("rst_ready", pix_ready_o, 1);
    chk("rst_init", comp_init_o, 0);
    chk("rst_data_zero", comp_data_o == '0, 1);
    chk("rst_index", comp_data_index_o, 0);
    chk("rst_mode", affine_param6_o, 0);

    // 6-param single pixel
    blk.delete(); add_pix(1, 0, 5, 2, 3);
    send_block(1'b1, 8'h11, 0);
    check_result("p6_single", 3);
    chk("p6_A14", comp_data_o[1][4], 6);
    chk("p6_A41", comp_data_o[4][1], 6);
    chk("p6_B4", comp_data_o[4][6], 15);

    // 4-param, same pixel
    blk.delete(); add_pix(1, 0, 5, 2, 3);
    send_block(1'b0, 8'h22, 0);
    check_result("p4_single", 3);
    chk("p4_A35", comp_data_o[3][5], 6);
    chk("p4_A01_zero", comp_data_o[0][1], 0);
    chk("p4_B3", comp_data_o[3][6], 10);

    // Back-to-back blocks; block 2 must not carry residue from block 1
    blk.delete(); repeat (4) add_pix(1, 1, 1, 0, 0);
    send_block(1'b1, 8'h31, 0);
    check_result("b2b_first", 3);
    blk.delete(); repeat (4) add_pix(1, 1, 2, 0, 0);
    send_block(1'b1, 8'h32, 2);
    chk("b2b_hold_old_B0", probe_val, 4);
    check_result("b2b_second", 3);
    chk("b2b_A02", comp_data_o[0][2], 4);
    chk("b2b_B2", comp_data_o[2][6], 8);

    // Mixed signs, 4-param multi-pixel
    blk.delete();
    add_pix(-300, 120, -77, 17, 90); add_pix(25, -4000, 311, 127, 0); add_pix(-1, -1, 1, 64, 127);
    send_block(1'b0, 8'h44, 0);
    check_result("p4_mixed", -1);

    // Mixed signs, 6-param multi-pixel
    blk.delete();
    add_pix(32767, -32768, -32768, 127, 127); add_pix(-5, 9, 13, 3, 100);
    send_block(1'b1, 8'h45, 0);
    check_result("p6_mixed", -1);

    // Solver not ready: WAIT holds for 20 cycles
    comp_load_i = 1'b0;
    blk.delete(); add_pix(7, -3, 4, 10, 20);
    send_block(1'b1, 8'h5A, 0);
    repeat (3) begin @(posedge clk); #1; end
    snap = comp_data_o;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      chk("wait_ready_low", pix_ready_o, 0);
      chk("wait_no_init", comp_init_o, 0);
      chk("wait_data_stable", comp_data_o == snap, 1);
    end
    comp_load_i = 1'b1;
    check_result("wait_release", 1);

    // Reset in the middle of a block
    beat('{3, -2, 7, 5, 9}, 1'b0, 1'b1, 8'h33);
    beat('{3, -2, 7, 5, 9}, 1'b0, 1'b1, 8'h33);
    beat('{3, -2, 7, 5, 9}, 1'b0, 1'b1, 8'h33);
    rst_i = 1'b1;
    #1;
    chk("midrst_data_zero", comp_data_o == '0, 1);
    chk("midrst_index", comp_data_index_o, 0);
    chk("midrst_init", comp_init_o, 0);
    chk("midrst_ready", pix_ready_o, 1);
    @(posedge clk); #1 rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk("midrst_no_init", comp_init_o, 0);
    end
    blk.delete(); add_pix(1, 0, 5, 2, 3);
    send_block(1'b1, 8'h11, 0);
    check_result("after_rst", 3);

    // Accumulator overflow of A11 in the 32-bit instance
    blk.delete(); repeat (8) add_pix(32767, 0, 1, 127, 0);
    send_block(1'b1, 8'h77, 0);
    check_result("ovf64", 3);
    p = 64'(32767 * 127);
    p = p * p * 8;
`ifdef AME_BUILDER_SAT_EN
    exp32 = 32'h7FFF_FFFF;
`else
    exp32 = p[31:0];
`endif
    chk("ovf32_A11", data32[1][1], exp32);
    chk("ovf32_tag", idx32, 8'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ame_equation_builder.md
Name: ame_equation_builder

Overview:
- Upstream feeder of ame_equation_solver in the affine motion estimation path.
- Consumes one pixel per cycle: horizontal/vertical gradient, residual and block-relative coordinate.
- Forms the per-pixel affine coefficient vector and accumulates the symmetric normal-equation matrix A and vector B over one block.
- Hands the 6x7 system to the solver through its comp_init/comp_load handshake.

Parameters:
- GRAD_BITS, 16, signed gradient and residual width.
- COORD_BITS, 7, unsigned block-relative x/y width (max block 128x128).
- COMP_DATA_BITS, 64, accumulator and output element width; must match the solver.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- pix_valid_i  in  1  pixel beat valid.
- pix_ready_o  out  1  beat accepted when valid&&ready.
- pix_last_i  in  1  last pixel of block.
- pix_gx_i  in  GRAD_BITS  signed horizontal gradient.
- pix_gy_i  in  GRAD_BITS  signed vertical gradient.
- pix_res_i  in  GRAD_BITS  signed residual (org - pred).
- pix_x_i  in  COORD_BITS  x position.
- pix_y_i  in  COORD_BITS  y position.
- affine_param6_i  in  1  mode: 1 = 6-param, 0 = 4-param; sampled on the first beat of a block.
- blk_index_i  in  8  block tag; sampled on the first beat.
- comp_load_i  in  1  solver ready (solver comp_load_o).
- comp_init_o  out  1  one-cycle start pulse to solver (solver comp_init_i).
- affine_param6_o  out  1  latched mode.
- comp_data_o  out  [5:0][6:0][COMP_DATA_BITS]  system: [i][j<6] = A[i][j], [i][6] = B[i].
- comp_data_index_o  out  8  latched block tag.

Behaviour:
- Reset: all outputs 0, except pix_ready_o = 1. State IDLE; accumulators 0.
- Coefficients, 6-param:
  - c0 = gx, c1 = x*gx, c2 = gy, c3 = x*gy, c4 = y*gx, c5 = y*gy.
  - Index k maps to row/col k.
- Coefficients, 4-param:
  - d0 = gx, d1 = x*gx + y*gy, d2 = gy, d3 = y*gx - x*gy.
  - d0..d3 map to rows/cols 2..5.
  - Rows/cols 0..1 and B0..B1 are forced to 0.
- Accumulation:
  - A[i][j] += c_i*c_j for j >= i only (21 accumulators); lower triangle is driven as a mirror.
  - B[i] += c_i*res.
  - Products are sign-extended to COMP_DATA_BITS; accumulation wraps mod 2^COMP_DATA_BITS.
- Pipeline:
  - S1 registers the coefficients.
  - S2 registers the 27 products.
  - S3 accumulates.
  - A first-beat flag travels with the data; at S3 it overwrites instead of adding, so no clear cycle is needed between blocks.
- FSM:
  - IDLE -> ACCUM on the first accepted beat.
  - ACCUM -> DRAIN on an accepted beat with pix_last_i. Also IDLE -> DRAIN directly for a 1-pixel block.
  - DRAIN lasts 2 cycles, until the last product lands in S3, then -> WAIT.
  - WAIT -> IDLE in the cycle comp_load_i = 1. comp_init_o is asserted registered in the following cycle (one pulse).
- pix_ready_o is 1 in IDLE and ACCUM, 0 in DRAIN and WAIT, and returns to 1 the cycle comp_init_o pulses.
- Latency: last beat accepted at T gives WAIT at T+3 and earliest comp_init_o at T+4.
- comp_data_o, comp_data_index_o and affine_param6_o stay stable from WAIT entry until the next block's first product reaches S3 (at least 3 cycles after comp_init_o).
- pix_valid_i without pix_last_i keeps accumulating indefinitely; no beat limit.
- pix_valid_i high while pix_ready_o = 0 is held off and not consumed.
- comp_load_i low in WAIT: wait indefinitely, outputs held.
- Async reset mid-block: the partial block is discarded, return to IDLE, no comp_init_o.

Optional Feature:
- AME_BUILDER_SAT_EN defined: each accumulator add saturates to the signed COMP_DATA_BITS range [-2^(N-1), 2^(N-1)-1].
- Once saturated, the value holds, but a later add of the opposite sign can pull it back in range.
- Undefined: plain two's-complement wrap.

Decomposition:
- Shared package ame_pkg holds:
  - the coefficient index constants (C_GX..C_YGY);
  - the upper-triangle index map (21 entries);
  - the FSM state enum;
  - the COMP_DATA_BITS default, also used by the solver.
- One sub-module, ame_coef_gen: combinational plus S1 register, mode-dependent coefficient formation, instantiated once.

Test Plan:
- 6-param single pixel gx=1, gy=0, x=2, y=3, res=5, last=1:
  - A00=1, A01=A10=2, A04=A40=3, A11=4, A14=A41=6, A44=9; B0=5, B1=10, B4=15; rest 0.
  - comp_init_o exactly one cycle, 4 cycles after the beat when comp_load_i is held 1.
- 4-param, same pixel:
  - A22=1, A23=2, A25=3, A33=4, A35=6, A55=9; B2=5, B3=10, B5=15.
  - Rows/cols 0..1 zero; affine_param6_o=0.
- Two back-to-back blocks (4 pixels each, gx=gy=res=1, all x=y=0), then a second block with res=2:
  - Second result A00=A02=A22=4, B0=B2=8.
  - Confirms overwrite-on-first-beat with no residue from block 1.
- comp_load_i held 0 for 20 cycles in WAIT:
  - pix_ready_o=0 and outputs stable.
  - comp_init_o fires the cycle after comp_load_i rises; blk_index tag 0x5A preserved.
- rst_i asserted during ACCUM after 3 beats:
  - All outputs 0 immediately, no comp_init_o.
  - Subsequent single-pixel block matches the first scenario.
- Overflow: COMP_DATA_BITS=32, gx=32767, x=127, 8 beats into A11:
  - With AME_BUILDER_SAT_EN, result is 0x7FFFFFFF.
  - Without it, result is the wrapped value 8*(32767*127)^2 mod 2^32.
